// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the instruction decoder (master)
// and the multi-cycle ALU (slave). Clock and reset stay as plain ports.
interface seq_alu_if #(
    parameter int WIDTH           = 8,
    parameter int INSTR_BIT_WIDTH = 5,
    parameter int FLAGS_COUNT     = 4
);
    logic                       Start;
    logic [INSTR_BIT_WIDTH-1:0] Instruction;
    logic [WIDTH-1:0]           InputA;
    logic [WIDTH-1:0]           InputB;
    logic [WIDTH-1:0]           ResultA;
    logic [WIDTH-1:0]           ResultB;
    logic [FLAGS_COUNT-1:0]     Flags;
    logic                       Busy;
    logic                       Done;

    modport master (
        output Start, Instruction, InputA, InputB,
        input  ResultA, ResultB, Flags, Busy, Done
    );

    modport slave (
        input  Start, Instruction, InputA, InputB,
        output ResultA, ResultB, Flags, Busy, Done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with Start/Busy/Done handshake.
// MUL is an iterative shift-add engine, DIV a restoring divider; both take
// WIDTH cycles. Every other op (and DIV by zero) completes on the accept edge.
// Flags = {DivZero, Overflow, Carry, Zero}.
// Optional feature: define SEQ_ALU_FAST_MUL_EN to replace the iterative MUL
// with a single-cycle combinational multiplier (MUL_RUN is then not built).
module seq_alu #(
    parameter int WIDTH           = 8,
    parameter int INSTR_BIT_WIDTH = 5,
    parameter int FLAGS_COUNT     = 4
) (
    input  logic         Clk,
    input  logic         ResetN,
    seq_alu_if.slave     bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH_V_INIT();

    localparam logic [INSTR_BIT_WIDTH-1:0] OP_ADD  = INSTR_BIT_WIDTH'(5'b00001);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_SUB  = INSTR_BIT_WIDTH'(5'b00010);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_MUL  = INSTR_BIT_WIDTH'(5'b00011);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_DIV  = INSTR_BIT_WIDTH'(5'b00100);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_SHL  = INSTR_BIT_WIDTH'(5'b00101);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_SHR  = INSTR_BIT_WIDTH'(5'b00110);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_ROL  = INSTR_BIT_WIDTH'(5'b00111);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_ROR  = INSTR_BIT_WIDTH'(5'b01000);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_AND  = INSTR_BIT_WIDTH'(5'b01001);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_XOR  = INSTR_BIT_WIDTH'(5'b01011);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_OR   = INSTR_BIT_WIDTH'(5'b01101);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_NAND = INSTR_BIT_WIDTH'(5'b01110);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_XNOR = INSTR_BIT_WIDTH'(5'b01111);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_GTH  = INSTR_BIT_WIDTH'(5'b10000);
    localparam logic [INSTR_BIT_WIDTH-1:0] OP_EQU  = INSTR_BIT_WIDTH'(5'b10001);

    // WIDTH always fits in WIDTH bits for WIDTH >= 2.
    function automatic logic [WIDTH-1:0] WIDTH_V_INIT();
        return WIDTH'(WIDTH);
    endfunction

    function automatic logic [FLAGS_COUNT-1:0] pack_flags(
        input logic dz, input logic ovf, input logic cy,
        input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb);
        return FLAGS_COUNT'({dz, ovf, cy, (ra == '0) && (rb == '0)});
    endfunction

`ifdef SEQ_ALU_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIV_RUN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DIV_RUN = 2'd2} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // MUL: {partial product high, multiplier/low product}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [WIDTH-1:0]       res_a_q, res_a_d, res_b_q, res_b_d;
    logic [FLAGS_COUNT-1:0] flags_q, flags_d;
    logic                   done_q, done_d;

    logic [WIDTH-1:0]       sc_a, sc_b;
    logic                   sc_c, sc_v, sc_dz;
    logic [WIDTH:0]         sum_ext, diff_ext;
    logic [SH_W-1:0]        rot_amt;
    logic [WIDTH:0]         div_shift, div_diff;
`ifdef SEQ_ALU_FAST_MUL_EN
    logic [2*WIDTH-1:0]     mul_full;
`else
    logic [WIDTH:0]         mul_sum;
`endif

    // Single-cycle datapath: result and flag candidates straight from the inputs
    always_comb begin
        sc_a     = '0;
        sc_b     = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_dz    = 1'b0;
        sum_ext  = {1'b0, bus.InputA} + {1'b0, bus.InputB};
        diff_ext = {1'b0, bus.InputA} - {1'b0, bus.InputB};
        rot_amt  = bus.InputB[SH_W-1:0];
`ifdef SEQ_ALU_FAST_MUL_EN
        mul_full = {{WIDTH{1'b0}}, bus.InputA} * {{WIDTH{1'b0}}, bus.InputB};
`endif
        case (bus.Instruction)
            OP_ADD: begin
                sc_a = sum_ext[WIDTH-1:0];
                sc_c = sum_ext[WIDTH];
                sc_v = (bus.InputA[WIDTH-1] == bus.InputB[WIDTH-1]) &&
                       (sum_ext[WIDTH-1] != bus.InputA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_a = diff_ext[WIDTH-1:0];
                sc_c = diff_ext[WIDTH];
                sc_v = (bus.InputA[WIDTH-1] != bus.InputB[WIDTH-1]) &&
                       (diff_ext[WIDTH-1] != bus.InputA[WIDTH-1]);
            end
`ifdef SEQ_ALU_FAST_MUL_EN
            OP_MUL: begin
                sc_a = mul_full[WIDTH-1:0];
                sc_b = mul_full[2*WIDTH-1:WIDTH];
                sc_c = (sc_b != '0);
            end
`endif
            OP_DIV: begin
                // only the divide-by-zero case completes here
                sc_a  = '1;
                sc_b  = bus.InputA;
                sc_dz = 1'b1;
            end
            OP_SHL:  sc_a = (bus.InputB >= WIDTH_V) ? '0 : (bus.InputA << bus.InputB);
            OP_SHR:  sc_a = (bus.InputB >= WIDTH_V) ? '0 : (bus.InputA >> bus.InputB);
            OP_ROL:  sc_a = (bus.InputA << rot_amt) | (bus.InputA >> (WIDTH - int'(rot_amt)));
            OP_ROR:  sc_a = (bus.InputA >> rot_amt) | (bus.InputA << (WIDTH - int'(rot_amt)));
            OP_AND:  sc_a = bus.InputA & bus.InputB;
            OP_XOR:  sc_a = bus.InputA ^ bus.InputB;
            OP_OR:   sc_a = bus.InputA | bus.InputB;
            OP_NAND: sc_a = ~(bus.InputA & bus.InputB);
            OP_XNOR: sc_a = ~(bus.InputA ^ bus.InputB);
            OP_GTH:  sc_a = WIDTH'(bus.InputA > bus.InputB);
            OP_EQU:  sc_a = WIDTH'(bus.InputA == bus.InputB);
            default: ; // NOP and unassigned opcodes leave both results 0
        endcase
    end

    // Control FSM plus one iteration step of the MUL / DIV engines
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
`ifndef SEQ_ALU_FAST_MUL_EN
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`endif
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
`ifndef SEQ_ALU_FAST_MUL_EN
                    if (bus.Instruction == OP_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, bus.InputB};
                        opnd_d  = bus.InputA;
                        cnt_d   = '0;
                        state_d = MUL_RUN;
                    end else
`endif
                    if (bus.Instruction == OP_DIV && bus.InputB != '0) begin
                        acc_d   = {{WIDTH{1'b0}}, bus.InputA};
                        opnd_d  = bus.InputB;
                        cnt_d   = '0;
                        state_d = DIV_RUN;
                    end else begin
                        res_a_d = sc_a;
                        res_b_d = sc_b;
                        flags_d = pack_flags(sc_dz, sc_v, sc_c, sc_a, sc_b);
                        done_d  = 1'b1;
                    end
                end
            end
`ifndef SEQ_ALU_FAST_MUL_EN
            MUL_RUN: begin
                // add multiplicand if multiplier LSB set, then shift right
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_LAST) begin
                    res_a_d = acc_d[WIDTH-1:0];
                    res_b_d = acc_d[2*WIDTH-1:WIDTH];
                    flags_d = pack_flags(1'b0, 1'b0, acc_d[2*WIDTH-1:WIDTH] != '0,
                                         acc_d[WIDTH-1:0], acc_d[2*WIDTH-1:WIDTH]);
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            DIV_RUN: begin
                // restoring step: keep the subtraction only if it did not go negative
                if (div_diff[WIDTH])
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                else
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_LAST) begin
                    res_a_d = acc_d[WIDTH-1:0];
                    res_b_d = acc_d[2*WIDTH-1:WIDTH];
                    flags_d = pack_flags(1'b0, 1'b0, 1'b0,
                                         acc_d[WIDTH-1:0], acc_d[2*WIDTH-1:WIDTH]);
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any running operation
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign bus.ResultA = res_a_q;
    assign bus.ResultB = res_b_q;
    assign bus.Flags   = flags_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state_q != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu at WIDTH=8.
module tb_seq_alu;
    localparam int W = 8;
`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int MUL_EDGES = 0;
`else
    localparam int MUL_EDGES = 8;
`endif

    localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00001, SUB = 5'b00010,
        MUL = 5'b00011, DIV = 5'b00100, SHL = 5'b00101, SHR = 5'b00110,
        ROL = 5'b00111, ROR = 5'b01000, XOR_ = 5'b01011, OR_ = 5'b01101,
        NAND_ = 5'b01110, XNOR_ = 5'b01111, GTH = 5'b10000, EQU = 5'b10001;

    logic Clk = 1'b0;
    logic ResetN = 1'b0;
    int   total = 0;
    int   bad = 0;

    seq_alu_if #(.WIDTH(W), .INSTR_BIT_WIDTH(5), .FLAGS_COUNT(4)) bus ();

    seq_alu #(.WIDTH(W), .INSTR_BIT_WIDTH(5), .FLAGS_COUNT(4)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    // Issue one op and wait (bounded) for Done; edges counts edges after the accept edge.
    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int edges, output logic busy_seen);
        @(negedge Clk);
        bus.Instruction = op;
        bus.InputA      = a;
        bus.InputB      = b;
        bus.Start       = 1'b1;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        edges     = 0;
        busy_seen = (bus.Busy === 1'b1);
        while (bus.Done !== 1'b1 && edges < 64) begin
            @(posedge Clk); #1;
            edges++;
            if (bus.Busy === 1'b1) busy_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.Instruction = NOP; bus.InputA = '0; bus.InputB = '0;
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if ({bus.ResultA, bus.ResultB, bus.Flags, bus.Busy, bus.Done} !== 22'd0) begin
            bad++;
            $display("FAIL reset_state: got A=%0d B=%0d F=%b busy=%b done=%b, want all 0",
                     bus.ResultA, bus.ResultB, bus.Flags, bus.Busy, bus.Done);
        end
        @(negedge Clk);
        ResetN = 1'b1;
        $display("reset: outputs A=%0d B=%0d F=%b", bus.ResultA, bus.ResultB, bus.Flags);
    endtask

    // One single-cycle op check: results, flags, zero latency and no Busy
    task automatic check_single(input string name, input logic [4:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] ef);
        int   e;
        logic bsy;
        run_op(op, a, b, e, bsy);
        total++;
        if (bus.ResultA !== ea || bus.ResultB !== eb || bus.Flags !== ef || e !== 0 || bsy !== 1'b0) begin
            bad++;
            $display("FAIL %s: got A=%0d B=%0d F=%b edges=%0d busy=%b, want A=%0d B=%0d F=%b edges=0 busy=0",
                     name, bus.ResultA, bus.ResultB, bus.Flags, e, bsy, ea, eb, ef);
        end
        $display("%s: a=%0d b=%0d -> A=%0d B=%0d F=%b", name, a, b, bus.ResultA, bus.ResultB, bus.Flags);
    endtask

    task automatic test_add();
        check_single("add_15_7", ADD, 8'd15, 8'd7, 8'd22, 8'd0, 4'b0000);
        @(posedge Clk); #1;
        total++;
        if (bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: Done=%b one edge later, want 0", bus.Done);
        end
        check_single("add_200_100", ADD, 8'd200, 8'd100, 8'd44, 8'd0, 4'b0010);
    endtask

    task automatic test_sub();
        check_single("sub_7_15", SUB, 8'd7, 8'd15, 8'd248, 8'd0, 4'b0010);
        check_single("sub_127_m1", SUB, 8'd127, 8'd255, 8'd128, 8'd0, 4'b0110);
    endtask

    task automatic test_logic_shift();
        check_single("rol_81_9", ROL, 8'h81, 8'd9, 8'h03, 8'd0, 4'b0000);
        check_single("ror_81_1", ROR, 8'h81, 8'd1, 8'hC0, 8'd0, 4'b0000);
        check_single("shl_15_8", SHL, 8'd15, 8'd8, 8'd0, 8'd0, 4'b0001);
        check_single("shr_f0_4", SHR, 8'hF0, 8'd4, 8'h0F, 8'd0, 4'b0000);
        check_single("gth_15_7", GTH, 8'd15, 8'd7, 8'd1, 8'd0, 4'b0000);
        check_single("gth_7_15", GTH, 8'd7, 8'd15, 8'd0, 8'd0, 4'b0001);
        check_single("equ_7_7", EQU, 8'd7, 8'd7, 8'd1, 8'd0, 4'b0000);
        check_single("nand_f0_ff", NAND_, 8'hF0, 8'hFF, 8'h0F, 8'd0, 4'b0000);
        check_single("xnor_aa_55", XNOR_, 8'hAA, 8'h55, 8'h00, 8'd0, 4'b0001);
        check_single("illegal_op", 5'b11111, 8'd9, 8'd9, 8'd0, 8'd0, 4'b0001);
        check_single("add_then_nop_setup", ADD, 8'd3, 8'd4, 8'd7, 8'd0, 4'b0000);
        check_single("nop_clears", NOP, 8'd3, 8'd4, 8'd0, 8'd0, 4'b0001);
    endtask

    // Iterative ops: results, flags and exact latency
    task automatic check_multi(input string name, input logic [4:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] ef,
                               input int ee);
        int   e;
        logic bsy;
        run_op(op, a, b, e, bsy);
        total++;
        if (bus.ResultA !== ea || bus.ResultB !== eb || bus.Flags !== ef || e !== ee) begin
            bad++;
            $display("FAIL %s: got A=%0d B=%0d F=%b edges=%0d, want A=%0d B=%0d F=%b edges=%0d",
                     name, bus.ResultA, bus.ResultB, bus.Flags, e, ea, eb, ef, ee);
        end
        $display("%s: a=%0d b=%0d -> A=%0d B=%0d F=%b edges=%0d busy_seen=%b",
                 name, a, b, bus.ResultA, bus.ResultB, bus.Flags, e, bsy);
    endtask

    task automatic test_mul();
        check_multi("mul_15_7", MUL, 8'd15, 8'd7, 8'd105, 8'd0, 4'b0000, MUL_EDGES);
        check_multi("mul_200_200", MUL, 8'd200, 8'd200, 8'h40, 8'h9C, 4'b0010, MUL_EDGES);
        check_multi("mul_255_255", MUL, 8'd255, 8'd255, 8'h01, 8'hFE, 4'b0010, MUL_EDGES);
        check_multi("mul_0_5", MUL, 8'd0, 8'd5, 8'd0, 8'd0, 4'b0001, MUL_EDGES);
    endtask

    task automatic test_div();
        int   e;
        logic bsy;
        check_multi("div_15_7", DIV, 8'd15, 8'd7, 8'd2, 8'd1, 4'b0000, 8);
        check_multi("div_250_3", DIV, 8'd250, 8'd3, 8'd83, 8'd1, 4'b0000, 8);
        check_multi("div_5_9", DIV, 8'd5, 8'd9, 8'd0, 8'd5, 4'b0000, 8);
        run_op(DIV, 8'd15, 8'd0, e, bsy);
        total++;
        if (bus.ResultA !== 8'd255 || bus.ResultB !== 8'd15 || bus.Flags !== 4'b1000 ||
            e !== 0 || bsy !== 1'b0) begin
            bad++;
            $display("FAIL div_by_zero: got A=%0d B=%0d F=%b edges=%0d busy=%b, want A=255 B=15 F=1000 edges=0 busy=0",
                     bus.ResultA, bus.ResultB, bus.Flags, e, bsy);
        end
        $display("div_15_0: A=%0d B=%0d F=%b edges=%0d", bus.ResultA, bus.ResultB, bus.Flags, e);
    endtask

    // OR held on Start during a DIV is ignored, then accepted right after Done
    task automatic test_busy_ignore();
        int e;
        @(negedge Clk);
        bus.Instruction = DIV; bus.InputA = 8'd15; bus.InputB = 8'd7; bus.Start = 1'b1;
        @(posedge Clk); #1;
        bus.Instruction = OR_; bus.InputA = 8'd15; bus.InputB = 8'd7;
        e = 0;
        while (bus.Done !== 1'b1 && e < 64) begin
            @(posedge Clk); #1;
            e++;
        end
        total++;
        if (bus.ResultA !== 8'd2 || bus.ResultB !== 8'd1 || e !== 8) begin
            bad++;
            $display("FAIL busy_ignore_div: got A=%0d B=%0d edges=%0d, want A=2 B=1 edges=8",
                     bus.ResultA, bus.ResultB, e);
        end
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        total++;
        if (bus.ResultA !== 8'd15 || bus.ResultB !== 8'd0 || bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL busy_ignore_or: got A=%0d B=%0d done=%b, want A=15 B=0 done=1",
                     bus.ResultA, bus.ResultB, bus.Done);
        end
        $display("busy_ignore: div edges=%0d then OR A=%0d", e, bus.ResultA);
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        bus.Instruction = ADD; bus.InputA = 8'd1; bus.InputB = 8'd1; bus.Start = 1'b1;
        @(posedge Clk); #1;
        total++;
        if (bus.ResultA !== 8'd2 || bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got A=%0d done=%b, want A=2 done=1", bus.ResultA, bus.Done);
        end
        @(negedge Clk);
        bus.Instruction = XOR_; bus.InputA = 8'h0F; bus.InputB = 8'hFF;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        total++;
        if (bus.ResultA !== 8'hF0 || bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got A=%0d done=%b, want A=240 done=1", bus.ResultA, bus.Done);
        end
        @(posedge Clk); #1;
        total++;
        if (bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_drop: Done=%b, want 0", bus.Done);
        end
        $display("back_to_back: last A=%0d", bus.ResultA);
    endtask

    task automatic test_reset_abort();
        int   e;
        logic bsy;
        logic done_seen;
        check_single("pre_abort_add", ADD, 8'd5, 8'd5, 8'd10, 8'd0, 4'b0000);
        @(negedge Clk);
        bus.Instruction = MUL; bus.InputA = 8'd15; bus.InputB = 8'd7; bus.Start = 1'b1;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        ResetN = 1'b0;
        #1;
        total++;
        if ({bus.ResultA, bus.ResultB, bus.Flags, bus.Busy, bus.Done} !== 22'd0) begin
            bad++;
            $display("FAIL abort_outputs: got A=%0d B=%0d F=%b busy=%b done=%b, want all 0",
                     bus.ResultA, bus.ResultB, bus.Flags, bus.Busy, bus.Done);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            if (bus.Done !== 1'b0) done_seen = 1'b1;
        end
        @(negedge Clk);
        ResetN = 1'b1;
        repeat (10) begin
            @(posedge Clk); #1;
            if (bus.Done !== 1'b0) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: Done observed=%b, want 0", done_seen);
        end
        run_op(ADD, 8'd1, 8'd2, e, bsy);
        total++;
        if (bus.ResultA !== 8'd3 || bus.Flags !== 4'b0000 || e !== 0) begin
            bad++;
            $display("FAIL abort_recover: got A=%0d F=%b edges=%0d, want A=3 F=0000 edges=0",
                     bus.ResultA, bus.Flags, e);
        end
        $display("reset_abort: recovered A=%0d", bus.ResultA);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_mul();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU, the next generation of the team's single-cycle ALU. It keeps the 5-bit opcode set but makes the data width a parameter and adds a Start/Busy/Done handshake. MUL and DIV run as iterative shift-add and restoring-divide engines, and every operation reports a 4-bit flag vector. It sits between the instruction decoder and the register file, and accepts one operation at a time.

## Interface
- WIDTH, 8: operand/result width; power of two, 4..64.
- INSTR_BIT_WIDTH, 5: opcode width.
- FLAGS_COUNT, 4: flag vector width, fixed order {DivZero, Overflow, Carry, Zero} (bit3..bit0).
- Clk  in  1  clock, rising edge.
- ResetN  in  1  reset, asynchronous and active-low; all state cleared while low.
- Start  in  1  request; sampled on Clk rising edge.
- Instruction  in  INSTR_BIT_WIDTH  opcode.
- InputA  in  WIDTH  operand A.
- InputB  in  WIDTH  operand B / shift amount.
- ResultA  out  WIDTH  primary result.
- ResultB  out  WIDTH  secondary result (MUL high half, DIV remainder, else 0).
- Flags  out  FLAGS_COUNT  status of the last completed operation.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse: results/flags just updated.

## Operation
- Opcodes: NOP 00000, ADD 00001, SUB 00010, MUL 00011, DIV 00100, SHL 00101, SHR 00110, ROL 00111, ROR 01000, AND 01001, XOR 01011, OR 01101, NAND 01110, XNOR 01111, GTH 10000, EQU 10001.
- Any other opcode executes as NOP.
- NOP: ResultA = ResultB = 0.
- Accept: Start=1 && Busy=0 at a rising edge. Instruction and operands are latched at that edge; later input changes are ignored.
- Start while Busy=1 is ignored, not queued.
- ADD/SUB: ResultA = (A±B) mod 2^WIDTH.
  - ADD: Carry = carry-out.
  - SUB: Carry = borrow (A<B unsigned).
  - Overflow = two's-complement signed overflow.
- SHL/SHR: logical shift by B. If B ≥ WIDTH, result is 0.
- ROL/ROR: rotate by B mod WIDTH.
- AND/XOR/OR/NAND/XNOR: bitwise.
- GTH: ResultA = (A>B unsigned). EQU: ResultA = (A==B). Both are zero-extended.
- MUL (unsigned): {ResultB, ResultA} = A*B. Carry = (ResultB != 0).
- DIV (unsigned): ResultA = A/B, ResultB = A%B.
- DIV with B=0: ResultA = all ones, ResultB = A, DivZero = 1, single-cycle latency.
- Zero = (ResultA == 0 && ResultB == 0) for all ops.
- Carry/Overflow/DivZero are 0 wherever not defined above.
- FSM states:
  - IDLE → MUL_RUN on accepted MUL.
  - IDLE → DIV_RUN on accepted DIV with B≠0.
  - MUL_RUN/DIV_RUN → IDLE when the iteration counter reaches WIDTH.
  - All other accepted ops complete in IDLE.
- Iteration counter is $clog2(WIDTH)+1 bits. Partial product / partial remainder are kept in internal registers. Outputs are not updated until completion.

## Timing
- Reset values: ResultA=0, ResultB=0, Flags=0, Busy=0, Done=0, state IDLE, counter 0.
- Single-cycle ops accepted at edge k: results, Flags, and Done=1 are visible after edge k; Done drops after edge k+1. Busy stays 0.
- MUL / DIV(B≠0) accepted at edge k:
  - Busy=1 after edge k.
  - One iteration per edge.
  - After edge k+WIDTH: results/Flags update, Done=1, Busy=0.
- Back-to-back: Start may be high in the cycle where Done=1. The new op is accepted at the next edge; throughput is 1 op/cycle for single-cycle ops.
- Results and Flags hold their value until the next completion (NOP also completes and clears them).
- ResetN low at any time, including mid-MUL/DIV: the operation is aborted, all outputs return to reset values immediately, and no Done is produced.

## Configuration
- SEQ_ALU_FAST_MUL_EN defined: MUL uses a combinational WIDTH×WIDTH multiplier with single-cycle latency and Busy never asserted for MUL. MUL_RUN state is not built.
- Undefined (default): iterative shift-add MUL with WIDTH-cycle latency as above.
- Results and flags are identical in both builds.

## Test plan
- WIDTH=8, ADD 15+7 → ResultA=22, ResultB=0, Flags=0000, Done one edge after accept. Then ADD 200+100 → ResultA=44, Carry=1.
- SUB 7−15 → ResultA=248, Carry=1, Overflow=0. SUB 127−(−1) (A=127, B=255) → ResultA=128, Overflow=1.
- MUL 15*7 → ResultA=105, ResultB=0, Done exactly 8 edges after accept (1 edge with SEQ_ALU_FAST_MUL_EN). MUL 200*200 → ResultA=0x40, ResultB=0x9C, Carry=1.
- DIV 15/7 → ResultA=2, ResultB=1 after 8 edges. DIV 15/0 → ResultA=255, ResultB=15, DivZero=1 after 1 edge, Busy never high.
- Start with OR 15|7 held high during a running DIV → ignored; DIV result unaffected; OR is accepted only once Busy=0.
- Drive ResetN low 3 cycles into a MUL → all outputs 0 immediately, no Done. After release, a new ADD completes normally.
- Rotate/shift: ROL 0x81 by 9 → 0x03; SHL 15 by 8 → 0, Zero=1; GTH 15>7 → 1; EQU 7==7 → 1.
